// File: rtl/alu_entry_sequencer.sv
// alu_entry_sequencer: front-panel entry controller for the ALU operand bank.
// Turns enter/back button presses into one-cycle load strobes for the five
// bank registers (A lo, A hi, B lo, B hi, opcode) and reports the entry stage.
//
// Build option: ENTRY_DEBOUNCE_EN inserts a per-button counter filter of
// DEBOUNCE_CYCLES between the synchronizer and the edge detector. Without it
// the edge detector reads the synchronizer output directly.
//
// state  | meaning
// -------+-----------------------------------------------
// S_A_LO | waiting for A low byte  (enter loads bank 0)
// S_A_HI | waiting for A high byte (enter loads bank 1)
// S_B_LO | waiting for B low byte  (enter loads bank 2)
// S_B_HI | waiting for B high byte (enter loads bank 3)
// S_OP   | waiting for opcode      (enter loads bank 4)
// S_SHOW | operation complete, result_valid high
module alu_entry_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       btn_enter,
  input  logic       btn_back,
  output logic [4:0] load,
  output logic [2:0] stage,
  output logic [5:0] stage_onehot,
  output logic       result_valid
);

  typedef enum logic [2:0] {
    S_A_LO = 3'd0,
    S_A_HI = 3'd1,
    S_B_LO = 3'd2,
    S_B_HI = 3'd3,
    S_OP   = 3'd4,
    S_SHOW = 3'd5
  } state_t;

  // A zero-length filter makes no sense; catch it at elaboration.
  if (DEBOUNCE_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("alu_entry_sequencer: DEBOUNCE_CYCLES and CNT_W must be at least 1");
  end

  // Bit 0 carries enter, bit 1 carries back through the conditioning path.
  logic [1:0] btn_raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] level;
  logic [1:0] level_prev;
  logic [1:0] press;

  assign btn_raw = {btn_back, btn_enter};

  // Two-stage synchronizer for the asynchronous button inputs.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef ENTRY_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt [2];
  logic [1:0]       filt;

  // Accept a new level only after it has differed from the filtered level on
  // DEBOUNCE_CYCLES consecutive edges; any return to the old level restarts.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      filt <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  // Previous accepted level; reset to 0 so a button held through reset
  // release still produces one press.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) level_prev <= '0;
    else             level_prev <= level;
  end

  assign press = level & ~level_prev;

  logic   go_enter;
  logic   go_back;
  state_t state_q;
  state_t state_d;
  logic [4:0] load_d;

  // Simultaneous enter and back cancel each other.
  assign go_enter = press[0] & ~press[1];
  assign go_back  = press[1] & ~press[0];

  // Next-state and load strobe decode.
  always_comb begin
    state_d = state_q;
    load_d  = '0;
    case (state_q)
      S_A_LO: begin
        if (go_enter) begin
          state_d = S_A_HI;
          load_d  = 5'b00001;
        end
      end
      S_A_HI: begin
        if (go_enter) begin
          state_d = S_B_LO;
          load_d  = 5'b00010;
        end else if (go_back) begin
          state_d = S_A_LO;
        end
      end
      S_B_LO: begin
        if (go_enter) begin
          state_d = S_B_HI;
          load_d  = 5'b00100;
        end else if (go_back) begin
          state_d = S_A_HI;
        end
      end
      S_B_HI: begin
        if (go_enter) begin
          state_d = S_OP;
          load_d  = 5'b01000;
        end else if (go_back) begin
          state_d = S_B_LO;
        end
      end
      S_OP: begin
        if (go_enter) begin
          state_d = S_SHOW;
          load_d  = 5'b10000;
        end else if (go_back) begin
          state_d = S_B_HI;
        end
      end
      S_SHOW: begin
        if (go_enter)     state_d = S_A_LO;
        else if (go_back) state_d = S_OP;
      end
      default: state_d = S_A_LO;
    endcase
  end

  // State and registered outputs, all derived from the next state so they
  // change on the same edge.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q      <= S_A_LO;
      load         <= '0;
      stage_onehot <= 6'b000001;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      load         <= load_d;
      stage_onehot <= 6'b000001 << state_d;
      result_valid <= (state_d == S_SHOW);
    end
  end

  assign stage = state_q;

endmodule
